// File: rtl/nivel_pkg.sv
// Shared types, level codes and pattern helpers for the tank-level encoder.
package nivel_pkg;

  typedef enum logic [2:0] {
    INICIO = 3'd0,
    VAZIO  = 3'd1,
    BAIXO  = 3'd2,
    MEDIO  = 3'd3,
    ALTO   = 3'd4,
    FALHA  = 3'd5
  } nivel_state_t;

  // {a,m,b} codes; water can only rise from the bottom, so these are the
  // only physically consistent switch patterns.
  localparam logic [2:0] COD_VAZIO = 3'b000;
  localparam logic [2:0] COD_BAIXO = 3'b001;
  localparam logic [2:0] COD_MEDIO = 3'b011;
  localparam logic [2:0] COD_ALTO  = 3'b111;

  localparam int DEBOUNCE_DEFAULT = 16;

  function automatic logic pat_legal(input logic [2:0] p);
    case (p)
      COD_VAZIO, COD_BAIXO, COD_MEDIO, COD_ALTO: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  // Level index 0..3; only meaningful for legal patterns.
  function automatic logic [1:0] pat_idx(input logic [2:0] p);
    case (p)
      COD_BAIXO: return 2'd1;
      COD_MEDIO: return 2'd2;
      COD_ALTO:  return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic nivel_state_t pat_state(input logic [2:0] p);
    case (p)
      COD_VAZIO: return VAZIO;
      COD_BAIXO: return BAIXO;
      COD_MEDIO: return MEDIO;
      COD_ALTO:  return ALTO;
      default:   return FALHA;
    endcase
  endfunction

  function automatic logic [2:0] state_code(input nivel_state_t s);
    case (s)
      BAIXO:   return COD_BAIXO;
      MEDIO:   return COD_MEDIO;
      ALTO:    return COD_ALTO;
      default: return COD_VAZIO;
    endcase
  endfunction

endpackage

// File: rtl/nivel_debounce_bit.sv
// One float switch: 2-flop synchroniser followed by a counting debouncer.
module nivel_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = nivel_pkg::DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_db
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] r_sync;
  logic [7:0] r_cnt;
  logic       r_db;

  // Synchronise, then flip the debounced value after DEBOUNCE_CYCLES
  // consecutive differing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
      r_cnt  <= 8'd0;
      r_db   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] != r_db) begin
        if (r_cnt == CNT_LAST) begin
          r_db  <= ~r_db;
          r_cnt <= 8'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/nivel_sensor_encoder.sv
// Tank-level front end: debounces three float switches, checks consistency
// and tracks the level, driving registered A/M/B/alarm codes and a fault flag.
module nivel_sensor_encoder
  import nivel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_alto,
  input  logic sw_medio,
  input  logic sw_baixo,
  input  logic fault_clr,
  output logic nivel_a,
  output logic nivel_m,
  output logic nivel_b,
  output logic alarm,
  output logic fault,
  output logic level_changed
);

  localparam logic [8:0] WIN_LAST = 9'(DEBOUNCE_CYCLES + 2);

  logic         w_db_a, w_db_m, w_db_b;
  logic [2:0]   w_pat;
  logic [2:0]   w_cur_idx, w_pat_idx;
  logic         w_adjacent, w_win_done;
  logic [8:0]   r_win;
  nivel_state_t r_state, w_next;
  logic [2:0]   r_code;
  logic         r_alarm, r_fault, r_lc;

  nivel_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
    .clk(clk), .rst_n(rst_n), .i_raw(sw_alto),  .o_db(w_db_a));
  nivel_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_m (
    .clk(clk), .rst_n(rst_n), .i_raw(sw_medio), .o_db(w_db_m));
  nivel_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
    .clk(clk), .rst_n(rst_n), .i_raw(sw_baixo), .o_db(w_db_b));

  assign w_pat      = {w_db_a, w_db_m, w_db_b};
  assign w_win_done = (r_win == WIN_LAST);
  // 3-bit indices so ALTO(3)+1 cannot wrap onto VAZIO(0).
  assign w_cur_idx  = {1'b0, pat_idx(state_code(r_state))};
  assign w_pat_idx  = {1'b0, pat_idx(w_pat)};
  assign w_adjacent = (w_pat_idx == w_cur_idx + 3'd1) ||
                      (w_cur_idx == w_pat_idx + 3'd1);

  // Power-on window: saturates once every debouncer has had a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_win <= 9'd0;
    else if (!w_win_done)      r_win <= r_win + 9'd1;
  end

  // Next-state: adjacent legal steps move, anything else latches FALHA.
  always_comb begin
    w_next = r_state;
    case (r_state)
      INICIO: if (w_win_done) w_next = pat_state(w_pat);
      VAZIO, BAIXO, MEDIO, ALTO: begin
        if (w_pat != state_code(r_state)) begin
          if (pat_legal(w_pat) && w_adjacent) w_next = pat_state(w_pat);
          else                                w_next = FALHA;
        end
      end
      FALHA: if (fault_clr && pat_legal(w_pat)) w_next = pat_state(w_pat);
      default: w_next = INICIO;
    endcase
  end

  // State and outputs registered together from the next-state value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INICIO;
      r_code  <= COD_VAZIO;
      r_alarm <= 1'b0;
      r_fault <= 1'b0;
      r_lc    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_code  <= state_code(w_next);
      r_alarm <= (w_next == VAZIO) || (w_next == FALHA);
      r_fault <= (w_next == FALHA);
      r_lc    <= (w_next != r_state) && (w_next != FALHA) && (w_next != INICIO);
    end
  end

  assign {nivel_a, nivel_m, nivel_b} = r_code;
  assign alarm         = r_alarm;
  assign fault         = r_fault;
  assign level_changed = r_lc;

endmodule
